// File: rtl/vector_alu_sequencer_pkg.sv
// Package for the vector ALU sequencer.
// Holds the ALU opcode encoding (it matches the scalar alu's opCode pins) and the
// sequencer FSM state type. Imported by the interface and the top module.
package vec_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_DIV = 2'd2,
        OP_SUB = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// Decode-side interface of the vector ALU sequencer.
// Carries the vector-op request channel (in_*) and the result channel (res_*).
//   master : decode stage / result consumer (drives in_* and res_ready)
//   slave  : the sequencer (drives in_ready and res_valid/res_data/res_zero/res_divz)
// Vectors are packed, lane 0 in the LSBs, each lane WIDTH+1 bits.
interface vector_alu_sequencer_if #(
    parameter int WIDTH     = 7,
    parameter int NUM_LANES = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [1:0]                     in_op;
    logic                           in_ci;
    logic [NUM_LANES-1:0]           in_mask;
    logic [NUM_LANES*(WIDTH+1)-1:0] in_a;
    logic [NUM_LANES*(WIDTH+1)-1:0] in_b;

    logic                           res_valid;
    logic                           res_ready;
    logic [NUM_LANES*(WIDTH+1)-1:0] res_data;
    logic                           res_zero;
    logic [NUM_LANES-1:0]           res_divz;

    modport master (
        output in_valid, in_op, in_ci, in_mask, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_zero, res_divz
    );

    modport slave (
        input  in_valid, in_op, in_ci, in_mask, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_zero, res_divz
    );
endinterface

// File: rtl/vector_alu_sequencer.sv
// Vector-op controller in front of the shared scalar alu.
// Accepts one packed NUM_LANES-element op per handshake, issues one lane per cycle
// to the alu, captures each lane result and returns the packed result vector with
// a folded zero flag and per-lane divide-by-zero flags.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   bus (slave)     : in_valid/in_ready/in_op/in_ci/in_mask/in_a/in_b request,
//                     res_valid/res_ready/res_data/res_zero/res_divz result
//   alu_a/b/op/ci   : registered drive of the alu inputs (0 outside ISSUE)
//   alu_out/cero    : alu combinational result for the lane currently driven
module vector_alu_sequencer
    import vec_alu_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int NUM_LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vector_alu_sequencer_if.slave bus,
    output logic [WIDTH:0]        alu_a,
    output logic [WIDTH:0]        alu_b,
    output logic [1:0]            alu_op,
    output logic                  alu_ci,
    input  logic [WIDTH:0]        alu_out,
    input  logic                  alu_cero
);

    localparam int EW = WIDTH + 1;
    localparam int VW = NUM_LANES * EW;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

    seq_state_e           state;
    logic [LW-1:0]        cnt;
    alu_op_e              op_q;
    logic                 ci_q;
    logic [NUM_LANES-1:0] mask_q;
    logic [VW-1:0]        a_q;
    logic [VW-1:0]        b_q;
    logic                 zero_acc;

    logic                 in_ready_q;
    logic                 res_valid_q;
    logic [VW-1:0]        res_data_q;
    logic                 res_zero_q;
    logic [NUM_LANES-1:0] res_divz_q;

    logic [LW-1:0]        nxt;
    logic [EW-1:0]        lane_b;
    logic                 lane_en;
    logic                 lane_divz;
    logic                 lane_live;
    logic                 zero_nxt;

    // Per-lane decisions for the lane currently on the alu pins.
    // A divide-by-zero lane is forced to 0 and kept out of the zero fold.
    always_comb begin
        nxt       = cnt + LW'(1);
        lane_b    = b_q[int'(cnt)*EW +: EW];
        lane_en   = mask_q[cnt];
        lane_divz = (op_q == OP_DIV) && lane_en && (lane_b == '0);
        lane_live = lane_en && !lane_divz;
        zero_nxt  = zero_acc & (!lane_live | alu_cero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= OP_ADD;
            ci_q        <= 1'b0;
            mask_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            zero_acc    <= 1'b0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_divz_q  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_ci      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= alu_op_e'(bus.in_op);
                        ci_q       <= bus.in_ci;
                        mask_q     <= bus.in_mask;
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        cnt        <= '0;
                        zero_acc   <= 1'b1;
                        res_data_q <= '0;
                        res_zero_q <= 1'b0;
                        res_divz_q <= '0;
                        in_ready_q <= 1'b0;
                        // Preload lane 0 so the first ISSUE cycle already sees it.
                        alu_a      <= bus.in_a[EW-1:0];
                        alu_b      <= bus.in_b[EW-1:0];
                        alu_op     <= bus.in_op;
                        alu_ci     <= bus.in_ci;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    res_data_q[int'(cnt)*EW +: EW] <= lane_live ? alu_out : '0;
                    res_divz_q[cnt]                <= lane_divz;
                    zero_acc                       <= zero_nxt;
                    if (cnt == LAST) begin
                        state       <= S_DONE;
                        res_valid_q <= 1'b1;
                        res_zero_q  <= zero_nxt;
                        // Park the alu at 0 so it never sees a stale DIV by 0.
                        alu_a       <= '0;
                        alu_b       <= '0;
                        alu_op      <= '0;
                        alu_ci      <= 1'b0;
                    end else begin
                        cnt    <= nxt;
                        alu_a  <= a_q[int'(nxt)*EW +: EW];
                        alu_b  <= b_q[int'(nxt)*EW +: EW];
                        alu_op <= op_q;
                        alu_ci <= ci_q;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_divz  = res_divz_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer (WIDTH=7, NUM_LANES=4) with a scalar alu
// model on the alu pins. Each op is checked against hand-computed literals, and a
// compare process checks every valid result against a lane-by-lane arithmetic model.
module tb_vector_alu_sequencer;

    localparam int WIDTH = 7;
    localparam int NL    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [1:0] alu_op;
    logic       alu_ci, alu_cero;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_data;
    logic        m_zero;
    logic [3:0]  m_divz;

    vector_alu_sequencer_if #(.WIDTH(WIDTH), .NUM_LANES(NL)) bus ();

    vector_alu_sequencer #(.WIDTH(WIDTH), .NUM_LANES(NL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_ci  (alu_ci),
        .alu_out (alu_out),
        .alu_cero(alu_cero)
    );

    always #5 clk = ~clk;

    // Scalar alu: ADD a+b+ci, MUL a*b, DIV a/b (0 when b==0), SUB a-b-ci.
    logic [15:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_op)
            2'd0: alu_t = 16'(alu_a) + 16'(alu_b) + 16'(alu_ci);
            2'd1: alu_t = 16'(alu_a) * 16'(alu_b);
            2'd2: alu_t = (alu_b == 8'd0) ? 16'd0 : 16'(alu_a / alu_b);
            default: alu_t = 16'(alu_a) - 16'(alu_b) - 16'(alu_ci);
        endcase
        alu_out  = alu_t[7:0];
        alu_cero = (alu_t[7:0] == 8'd0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Whole-vector expectation from plain per-lane arithmetic.
    task automatic model(input logic [1:0] op, input logic ci, input logic [3:0] mask,
                         input logic [31:0] a, input logic [31:0] b);
        int x, ai, bi;
        m_data = '0; m_zero = 1'b1; m_divz = '0;
        for (int i = 0; i < NL; i++) begin
            ai = int'(a[8*i +: 8]);
            bi = int'(b[8*i +: 8]);
            x  = 0;
            if (mask[i]) begin
                if (op == 2'd2 && bi == 0) m_divz[i] = 1'b1;
                else begin
                    case (op)
                        2'd0: x = ai + bi + int'(ci);
                        2'd1: x = ai * bi;
                        2'd2: x = ai / bi;
                        default: x = ai - bi - int'(ci);
                    endcase
                    m_data[8*i +: 8] = 8'(x & 255);
                    if ((x & 255) != 0) m_zero = 1'b0;
                end
            end
        end
    endtask

    // Every cycle: a valid result must match the model; alu pins idle at 0 outside ISSUE.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.res_valid) begin
                chk("mdl_data", 64'(bus.res_data), 64'(m_data));
                chk("mdl_zero", 64'(bus.res_zero), 64'(m_zero));
                chk("mdl_divz", 64'(bus.res_divz), 64'(m_divz));
            end
            if (bus.in_ready || bus.res_valid)
                chk("alu_idle", 64'({alu_a, alu_b, alu_op, alu_ci}), 64'd0);
        end
    end

    // Accept one op, check latency, then check the result against literals.
    // Leaves the bench #1 after the edge on which res_valid rose.
    task automatic run_op(input string name, input logic [1:0] op, input logic ci,
                          input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_data, input logic e_zero, input logic [3:0] e_divz);
        int w;
        @(negedge clk);
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_ready"}, 64'(bus.in_ready), 64'd1);
        model(op, ci, mask, a, b);
        bus.in_op = op; bus.in_ci = ci; bus.in_mask = mask;
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a = $urandom; bus.in_b = $urandom;
        for (int k = 1; k <= NL; k++) begin
            @(posedge clk); #1;
            chk({name, "_lat"}, 64'(bus.res_valid), 64'(k == NL));
        end
        chk({name, "_busy"}, 64'(bus.in_ready), 64'd0);
        chk({name, "_data"}, 64'(bus.res_data), 64'(e_data));
        chk({name, "_zero"}, 64'(bus.res_zero), 64'(e_zero));
        chk({name, "_divz"}, 64'(bus.res_divz), 64'(e_divz));
    endtask

    task automatic finish_op(input string name);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_hs_valid"}, 64'(bus.res_valid), 64'd0);
        chk({name, "_hs_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_ci = 1'b0; bus.in_mask = '0;
        bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b1;
        m_data = '0; m_zero = 1'b0; m_divz = '0;
        #12;
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res", 64'({bus.res_data, bus.res_zero, bus.res_divz}), 64'd0);
        chk("rst_alu", 64'({alu_a, alu_b, alu_op, alu_ci}), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("add", 2'd0, 1'b0, 4'hF, pk(8'h05, 8'h05, 8'h05, 8'h05), pk(8'h05, 8'h05, 8'h05, 8'h05),
               pk(8'h0A, 8'h0A, 8'h0A, 8'h0A), 1'b0, 4'b0000);
        finish_op("add");
        run_op("sub", 2'd3, 1'b0, 4'hF, pk(8'h05, 8'h60, 8'h01, 8'hFF), pk(8'h05, 8'h60, 8'h01, 8'hFF),
               32'h0, 1'b1, 4'b0000);
        finish_op("sub");
        run_op("mul", 2'd1, 1'b0, 4'hF, pk(8'h03, 8'h10, 8'h02, 8'h01), pk(8'h04, 8'h10, 8'h02, 8'h00),
               pk(8'h0C, 8'h00, 8'h04, 8'h00), 1'b0, 4'b0000);
        finish_op("mul");
        run_op("div", 2'd2, 1'b0, 4'hF, pk(8'h08, 8'h08, 8'h09, 8'h07), pk(8'h02, 8'h00, 8'h03, 8'h00),
               pk(8'h04, 8'h00, 8'h03, 8'h00), 1'b0, 4'b1010);
        finish_op("div");
        run_op("mask0", 2'd3, 1'b0, 4'h0, pk(8'h01, 8'h01, 8'h01, 8'h01), pk(8'h01, 8'h01, 8'h01, 8'h01),
               32'h0, 1'b1, 4'b0000);
        finish_op("mask0");
        run_op("mask1", 2'd3, 1'b0, 4'h1, pk(8'h02, 8'h01, 8'h01, 8'h01), pk(8'h01, 8'h01, 8'h01, 8'h01),
               pk(8'h01, 8'h00, 8'h00, 8'h00), 1'b0, 4'b0000);
        finish_op("mask1");
        // Carry-in on every lane; lane 3 carries out and is dropped.
        run_op("addci", 2'd0, 1'b1, 4'hF, pk(8'h01, 8'h02, 8'h03, 8'hFF), pk(8'h01, 8'h01, 8'h01, 8'h00),
               pk(8'h03, 8'h04, 8'h05, 8'h00), 1'b0, 4'b0000);
        finish_op("addci");

        // Back-pressure: result must hold and a new offer must be ignored.
        bus.res_ready = 1'b0;
        run_op("hold", 2'd0, 1'b0, 4'hF, pk(8'h05, 8'h05, 8'h05, 8'h05), pk(8'h05, 8'h05, 8'h05, 8'h05),
               pk(8'h0A, 8'h0A, 8'h0A, 8'h0A), 1'b0, 4'b0000);
        bus.in_op = 2'd1; bus.in_a = 32'h11223344; bus.in_b = 32'h55667788;
        bus.in_mask = 4'hF; bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_data", 64'(bus.res_data), 64'(pk(8'h0A, 8'h0A, 8'h0A, 8'h0A)));
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        finish_op("hold");

        // Reset in the middle of ISSUE aborts the op.
        @(negedge clk);
        model(2'd1, 1'b0, 4'hF, pk(8'h03, 8'h03, 8'h03, 8'h03), pk(8'h02, 8'h02, 8'h02, 8'h02));
        bus.in_op = 2'd1; bus.in_ci = 1'b0; bus.in_mask = 4'hF;
        bus.in_a = pk(8'h03, 8'h03, 8'h03, 8'h03); bus.in_b = pk(8'h02, 8'h02, 8'h02, 8'h02);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_alu_a", 64'(alu_a), 64'h03);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.res_valid), 64'd0);
        chk("arst_res", 64'({bus.res_data, bus.res_zero, bus.res_divz}), 64'd0);
        chk("arst_alu", 64'({alu_a, alu_b, alu_op, alu_ci}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_noresult", 64'(bus.res_valid), 64'd0);

        run_op("again", 2'd0, 1'b0, 4'hF, pk(8'h05, 8'h05, 8'h05, 8'h05), pk(8'h05, 8'h05, 8'h05, 8'h05),
               pk(8'h0A, 8'h0A, 8'h0A, 8'h0A), 1'b0, 4'b0000);
        finish_op("again");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
